add_sat_stage: RTL and testbench

Downstream result stage for the signed ripple-carry adder. It accepts the adder's sum, its signed-overflow flag, and the common operand sign through a valid/ready handshake, and clamps overflowed results to the signed min/max. Results are buffered in a 2-entry in-order skid FIFO so the adder path gets full throughput under backpressure. It also keeps a saturating count of overflow events for debug/perf readout.

---
 rtl/add_sat_stage.sv | 132 +++++++++++++
 tb/tb_add_sat_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/add_sat_stage.sv
// add_sat_stage: clamps the adder's signed-overflowed sums to the signed min/max
// and buffers {data, sat} results in a 2-entry in-order skid FIFO.
// Latency: a result accepted at edge N is presented on out_data in cycle N+1.
// Backpressure: in_ready depends only on registered occupancy (never on out_ready).
// Ports:
//   clk, reset           single clock; asynchronous active-high reset
//   in_valid/in_ready    upstream handshake carrying in_sum, in_ovf, in_sign
//   out_valid/out_ready  downstream handshake carrying out_data, out_sat
//   clear_count          synchronous clear of the overflow event counter
//   ovf_count            saturating count of accepted overflowed results
module add_sat_stage #(
  parameter int unsigned Bits    = 64,
  parameter int unsigned CntBits = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Bits-1:0]    in_sum,
  input  logic               in_ovf,
  input  logic               in_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Bits-1:0]    out_data,
  output logic               out_sat,
  input  logic               clear_count,
  output logic [CntBits-1:0] ovf_count
);

  // Clamp targets: largest positive and most negative two's-complement values.
  localparam logic [Bits-1:0]    MaxPos = {1'b0, {(Bits-1){1'b1}}};
  localparam logic [Bits-1:0]    MinNeg = {1'b1, {(Bits-1){1'b0}}};
  localparam logic [CntBits-1:0] CntOne = CntBits'(1);
  localparam logic [CntBits-1:0] CntMax = {CntBits{1'b1}};

  // FIFO storage and bookkeeping.
  logic [Bits-1:0]    data_q [2];
  logic [Bits-1:0]    data_d [2];
  logic [1:0]         sat_q;
  logic [1:0]         sat_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         occ_q, occ_d;
  logic [CntBits-1:0] cnt_q, cnt_d;

  logic               accept;
  logic               emit;
  logic [Bits-1:0]    sat_data;

  // Handshake status comes straight from occupancy so there is no
  // combinational path between out_ready and in_ready.
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  // When the adder overflowed, both operands shared a sign, so the true result
  // lies beyond the range on that side; in_sign is ignored otherwise.
  always_comb begin
    sat_data = in_sum;
    if (in_ovf) begin
      sat_data = in_sign ? MinNeg : MaxPos;
    end
  end

  // FIFO next state.
  always_comb begin
    data_d   = data_q;
    sat_d    = sat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (accept) begin
      data_d[wr_ptr_q] = sat_data;
      sat_d[wr_ptr_q]  = in_ovf;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (emit) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Simultaneous accept and emit leave occupancy unchanged; accept cannot
    // happen when full because in_ready is low.
    unique case ({accept, emit})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Overflow counter: a clear wins over the increment, but an overflowed
  // accept in the same cycle as the clear still counts as the first event.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = (accept && in_ovf) ? CntOne : '0;
    end else if (accept && in_ovf && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      sat_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      cnt_q     <= '0;
    end else begin
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
      sat_q     <= sat_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      cnt_q     <= cnt_d;
    end
  end

  // Head entry is held in registers, so it stays stable while stalled.
  assign out_data  = data_q[rd_ptr_q];
  assign out_sat   = sat_q[rd_ptr_q];
  assign ovf_count = cnt_q;

  // Occupancy is a 0..2 count; the encoding 3 must never be reached.
  occ_range_a: assert property (@(posedge clk) disable iff (reset) occ_q != 2'd3);

endmodule

// File: tb/tb_add_sat_stage.sv
module tb_add_sat_stage;
  localparam int B    = 8;
  localparam int C    = 2;
  localparam int CMAX = (1 << C) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [B-1:0] in_sum;
  logic         in_ovf;
  logic         in_sign;
  logic         out_valid;
  logic         out_ready;
  logic [B-1:0] out_data;
  logic         out_sat;
  logic         clear_count;
  logic [C-1:0] ovf_count;

  add_sat_stage #(.Bits(B), .CntBits(C)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_ovf(in_ovf), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat),
    .clear_count(clear_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending results plus an integer counter.
  typedef struct {
    logic [B-1:0] d;
    logic         s;
  } ent_t;

  ent_t q[$];
  int   cnt;
  int   checks = 0;
  int   errors = 0;
  logic [B-1:0] min_v;
  logic [B-1:0] max_v;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      check({tag, ".out_data"}, 64'(out_data), 64'(q[0].d));
      check({tag, ".out_sat"}, 64'(out_sat), 64'(q[0].s));
    end
    check({tag, ".ovf_count"}, 64'(ovf_count), 64'(cnt));
  endtask

  // Called at a falling edge: drives inputs, advances the model across the
  // next rising edge, then checks the DUT at the following falling edge.
  task automatic cycle(input string tag, input logic v, input logic [B-1:0] s,
                       input logic o, input logic sg, input logic ordy, input logic clr);
    bit   acc, emi;
    ent_t e;
    in_valid    = v;
    in_sum      = s;
    in_ovf      = o;
    in_sign     = sg;
    out_ready   = ordy;
    clear_count = clr;
    acc = v && (q.size() < 2);
    emi = (q.size() != 0) && ordy;
    @(posedge clk);
    if (emi) void'(q.pop_front());
    if (acc) begin
      e.d = o ? (sg ? min_v : max_v) : s;
      e.s = o;
      q.push_back(e);
    end
    if (clr) cnt = (acc && o) ? 1 : 0;
    else if (acc && o && cnt < CMAX) cnt++;
    @(negedge clk);
    check_outs(tag);
  endtask

  initial begin
    min_v = 1 << (B - 1);
    max_v = min_v - 1;
    cnt = 0;
    reset = 1'b1;
    in_valid = 0; in_sum = 0; in_ovf = 0; in_sign = 0;
    out_ready = 0; clear_count = 0;
    #12;
    check("rst.out_valid", 64'(out_valid), 0);
    check("rst.out_data", 64'(out_data), 0);
    check("rst.out_sat", 64'(out_sat), 0);
    check("rst.in_ready", 64'(in_ready), 1);
    check("rst.ovf_count", 64'(ovf_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic saturation cases.
    cycle("nov", 1, 8'h35, 0, 1, 1, 0);
    check("nov.data", 64'(out_data), 64'h35);
    check("nov.sat", 64'(out_sat), 0);
    cycle("pov", 1, 8'h80, 1, 0, 1, 0);
    check("pov.data", 64'(out_data), 64'h7F);
    check("pov.sat", 64'(out_sat), 1);
    check("pov.cnt", 64'(ovf_count), 1);
    cycle("nneg", 1, 8'h7E, 1, 1, 1, 0);
    check("nneg.data", 64'(out_data), 64'h80);
    check("nneg.cnt", 64'(ovf_count), 2);
    cycle("drain", 0, 8'h00, 0, 0, 1, 0);

    // Backpressure: third value is held upstream until space frees up.
    cycle("bp1", 1, 8'h01, 0, 0, 0, 0);
    cycle("bp2", 1, 8'h02, 0, 0, 0, 0);
    check("bp.in_ready_low", 64'(in_ready), 0);
    cycle("bp3", 1, 8'h03, 0, 0, 0, 0);
    check("bp.head_stable", 64'(out_data), 64'h01);
    cycle("bp4", 1, 8'h03, 0, 0, 0, 0);
    check("bp.head_stable2", 64'(out_data), 64'h01);
    cycle("bpe1", 1, 8'h03, 0, 0, 1, 0);
    check("bp.second", 64'(out_data), 64'h02);
    check("bp.in_ready_back", 64'(in_ready), 1);
    cycle("bpe2", 1, 8'h03, 0, 0, 1, 0);
    check("bp.third", 64'(out_data), 64'h03);
    cycle("bpe3", 0, 8'h00, 0, 0, 1, 0);

    // Full-rate stream.
    for (int i = 0; i < 16; i++) begin
      cycle("stream", 1, 8'(i * 7 + 3), 0, 0, 1, 0);
      check("stream.in_ready", 64'(in_ready), 1);
    end
    cycle("stream_end", 0, 8'h00, 0, 0, 1, 0);

    // Counter saturation and clear priority.
    cycle("clr0", 0, 8'h00, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cycle("cnt", 1, 8'h55, 1, i[0], 1, 0);
      check("cnt.sat_seq", 64'(ovf_count), 64'((i < 3) ? i + 1 : 3));
    end
    cycle("clr_ovf", 1, 8'h11, 1, 0, 1, 1);
    check("clr_ovf.cnt", 64'(ovf_count), 1);
    cycle("clr_only", 0, 8'h00, 0, 0, 1, 1);
    check("clr_only.cnt", 64'(ovf_count), 0);

    // Asynchronous reset with a full FIFO.
    cycle("fill1", 1, 8'hA1, 1, 0, 0, 0);
    cycle("fill2", 1, 8'hA2, 0, 0, 0, 0);
    check("fill.full", 64'(in_ready), 0);
    reset = 1'b1;
    #1;
    check("arst.out_valid", 64'(out_valid), 0);
    check("arst.in_ready", 64'(in_ready), 1);
    check("arst.ovf_count", 64'(ovf_count), 0);
    q.delete();
    cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    cycle("post_rst_idle", 0, 8'h00, 0, 0, 1, 0);
    cycle("post_rst_acc", 1, 8'h5C, 0, 0, 1, 0);
    check("post_rst.data", 64'(out_data), 64'h5C);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
